// File: rtl/lut_cfg_loader.sv
// Serial configuration loader for a fracturable LUT: shifts a frame in MSB first and commits it atomically.
// Optional build macro LUT_CFG_PARITY_EN appends a trailing even-parity bit to each frame.
module lut_cfg_loader #(
    parameter int INPUTS    = 4,
    parameter int MEM_SIZE  = 2**INPUTS,
    parameter int CFG_WIDTH = 2*MEM_SIZE+1
) (
    input  logic                 cclk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 cfg_bit,
    input  logic                 cfg_valid,
    input  logic                 cfg_last,
    output logic                 cfg_ready,
    output logic [CFG_WIDTH-1:0] config_out,
    output logic                 cen_out,
    output logic                 done,
    output logic                 err
);

    localparam int CNT_W = $clog2(CFG_WIDTH+2);
`ifdef LUT_CFG_PARITY_EN
    localparam int FRAME_LEN = CFG_WIDTH + 1;
`else
    localparam int FRAME_LEN = CFG_WIDTH;
`endif
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CHECK,
        COMMIT,
        ERR
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [CNT_W-1:0]       cnt_inc;
    logic [CFG_WIDTH-1:0]   shift_reg;
    logic                   accept;
    logic                   begin_frame;
    logic                   frame_ok;
    logic                   load_cfg;
`ifdef LUT_CFG_PARITY_EN
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(CFG_WIDTH);
    logic                   par_acc;
`endif

    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Counter saturates instead of wrapping so a runaway frame can never alias a legal length.
    always_comb begin
        cnt_inc = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + CNT_W'(1);
`ifdef LUT_CFG_PARITY_EN
        frame_ok = (bit_cnt == FRAME_CNT) && !par_acc;
`else
        frame_ok = (bit_cnt == FRAME_CNT);
`endif
    end

    always_comb begin
        next_state  = state;
        cfg_ready   = 1'b0;
        cen_out     = 1'b0;
        accept      = 1'b0;
        begin_frame = 1'b0;
        load_cfg    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    begin_frame = 1'b1;
                    next_state  = SHIFT;
                end
            end
            SHIFT: begin
                cfg_ready = 1'b1;
                accept    = cfg_valid;
                if (accept) begin
                    if (cfg_last) begin
                        next_state = CHECK;
                    end else if (cnt_inc == FRAME_CNT) begin
                        next_state = ERR;
                    end
                end
            end
            CHECK: begin
                if (frame_ok) begin
                    load_cfg   = 1'b1;
                    next_state = COMMIT;
                end else begin
                    next_state = ERR;
                end
            end
            COMMIT: begin
                cen_out    = 1'b1;
                next_state = IDLE;
            end
            ERR: begin
                if (start) begin
                    begin_frame = 1'b1;
                    next_state  = SHIFT;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // config_out is only ever written from a fully checked frame, so the LUT never sees partial data.
    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            bit_cnt    <= '0;
            shift_reg  <= '0;
            config_out <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
            par_acc    <= 1'b0;
`endif
        end else begin
            if (begin_frame) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
                done      <= 1'b0;
                err       <= 1'b0;
`ifdef LUT_CFG_PARITY_EN
                par_acc   <= 1'b0;
`endif
            end
            if (accept) begin
                bit_cnt <= cnt_inc;
`ifdef LUT_CFG_PARITY_EN
                par_acc <= par_acc ^ cfg_bit;
                if (bit_cnt < DATA_CNT) begin
                    shift_reg <= {shift_reg[CFG_WIDTH-2:0], cfg_bit};
                end
`else
                shift_reg <= {shift_reg[CFG_WIDTH-2:0], cfg_bit};
`endif
            end
            if (load_cfg) begin
                config_out <= shift_reg;
            end
            if (state == COMMIT) begin
                done <= 1'b1;
            end
            if ((next_state == ERR) && (state != ERR)) begin
                err <= 1'b1;
            end
        end
    end

endmodule
